// File: rtl/timer_pkg.sv
// Shared types and defaults for the loadable countdown timer.
package timer_pkg;

   localparam int unsigned TIMER_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } timer_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with idle/run/paused control and a one-cycle expiry pulse.
// Controls resolve with priority load > pause > start > tick.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH  = TIMER_WIDTH,
   parameter bit          RELOAD = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done
);

   timer_state_e     r_state_q, r_state_d;
   logic [WIDTH-1:0] r_out_q, r_out_d;
   logic [WIDTH-1:0] r_rld_q, r_rld_d;
   logic             r_done_q, r_done_d;
   logic             w_expire;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state_q <= IDLE;
         r_out_q   <= '0;
         r_rld_q   <= '0;
         r_done_q  <= 1'b0;
      end else begin
         r_state_q <= r_state_d;
         r_out_q   <= r_out_d;
         r_rld_q   <= r_rld_d;
         r_done_q  <= r_done_d;
      end
   end

   // Reaching the last count; out==0 in RUN cannot occur but expires safely.
   assign w_expire = (r_out_q <= WIDTH'(1));

   always_comb begin
      r_state_d = r_state_q;
      r_out_d   = r_out_q;
      r_rld_d   = r_rld_q;
      r_done_d  = 1'b0;
      if (load) begin
         r_state_d = IDLE;
         r_out_d   = load_val;
         r_rld_d   = load_val;
      end else begin
         unique case (r_state_q)
            IDLE: begin
               if (start) begin
                  if (r_out_q != '0) r_state_d = RUN;
                  else               r_done_d  = 1'b1;
               end
            end
            RUN: begin
               if (pause) begin
                  r_state_d = PAUSED;
               end else if (tick) begin
                  if (!w_expire) begin
                     r_out_d = r_out_q - WIDTH'(1);
                  end else begin
                     r_done_d = 1'b1;
                     if (RELOAD && (r_rld_q != '0)) begin
                        r_out_d = r_rld_q;
                     end else begin
                        r_out_d   = '0;
                        r_state_d = IDLE;
                     end
                  end
               end
            end
            PAUSED: begin
               if (!pause && start) r_state_d = RUN;
            end
            default: r_state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      out  = r_out_q;
      done = r_done_q;
      busy = (r_state_q != IDLE);
   end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer; RELOAD=0 and RELOAD=1 instances
// share stimulus and are each compared against a behavioural model every cycle.
module tb_countdown_timer;
   import timer_pkg::*;

   localparam int unsigned W = TIMER_WIDTH;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         tick = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         start = 1'b0;
   logic         pause = 1'b0;
   logic [W-1:0] out0, out1;
   logic         busy0, busy1, done0, done1;

   int n_checks = 0;
   int n_fails  = 0;

   // Model: remaining count, reload value, running/paused flags, expected done.
   int m_out   [2];
   int m_rld   [2];
   bit m_run   [2];
   bit m_pause [2];
   bit m_done  [2];

   always #5 clk = ~clk;

   countdown_timer #(.WIDTH(W), .RELOAD(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .out(out0), .busy(busy0), .done(done0)
   );

   countdown_timer #(.WIDTH(W), .RELOAD(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .tick(tick), .load(load), .load_val(load_val),
      .start(start), .pause(pause), .out(out1), .busy(busy1), .done(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_out[k] = 0; m_rld[k] = 0; m_run[k] = 0; m_pause[k] = 0; m_done[k] = 0;
      end
   endtask

   task automatic check_all(input string ctx);
      check({ctx, " out0"},  32'(out0),  32'(m_out[0]));
      check({ctx, " busy0"}, 32'(busy0), 32'(m_run[0] | m_pause[0]));
      check({ctx, " done0"}, 32'(done0), 32'(m_done[0]));
      check({ctx, " out1"},  32'(out1),  32'(m_out[1]));
      check({ctx, " busy1"}, 32'(busy1), 32'(m_run[1] | m_pause[1]));
      check({ctx, " done1"}, 32'(done1), 32'(m_done[1]));
   endtask

   // Apply one cycle of controls, advance the model by the rules, then compare.
   task automatic step(input bit ld, input int val, input bit st, input bit ps, input bit tk,
                       input string ctx);
      load = ld; load_val = W'(val); start = st; pause = ps; tick = tk;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         m_done[k] = 0;
         if (ld) begin
            m_out[k] = val; m_rld[k] = val; m_run[k] = 0; m_pause[k] = 0;
         end else if (m_pause[k]) begin
            if (!ps && st) begin m_pause[k] = 0; m_run[k] = 1; end
         end else if (m_run[k]) begin
            if (ps) begin
               m_run[k] = 0; m_pause[k] = 1;
            end else if (tk) begin
               if (m_out[k] > 1) begin
                  m_out[k] = m_out[k] - 1;
               end else begin
                  m_done[k] = 1;
                  if (k == 1 && m_rld[k] != 0) m_out[k] = m_rld[k];
                  else begin m_out[k] = 0; m_run[k] = 0; end
               end
            end
         end else if (st) begin
            if (m_out[k] != 0) m_run[k] = 1;
            else               m_done[k] = 1;
         end
      end
      #1;
      check_all(ctx);
   endtask

   initial begin
      int done_cnt;
      model_reset();
      #2;
      check_all("por");
      #15 rst_n = 1'b1;

      // Basic countdown from 7 with continuous tick.
      step(1, 7, 0, 0, 0, "cd_load");
      step(0, 0, 1, 0, 0, "cd_start");
      done_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 0, 0, 1, "cd_tick");
         if (done0) done_cnt++;
      end
      check("cd_done_once", 32'(done_cnt), 32'd1);
      check("cd_final_out", 32'(out0), 32'd0);

      // Pause at out=2 with sparse ticks, then resume.
      step(1, 4, 0, 0, 0, "pr_load");
      step(0, 0, 1, 0, 0, "pr_start");
      for (int i = 0; i < 30 && m_out[0] != 2; i++) step(0, 0, 0, 0, (i % 3) == 2, "pr_tick");
      for (int i = 0; i < 10; i++) step(0, 0, 0, 1, (i % 3) == 0, "pr_hold");
      check("pr_held_out", 32'(out0), 32'd2);
      step(0, 0, 1, 0, 1, "pr_resume");
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, (i % 3) == 2, "pr_run");

      // All controls at once while running: load wins.
      step(1, 5, 0, 0, 0, "pri_load");
      step(0, 0, 1, 0, 0, "pri_start");
      step(0, 0, 0, 0, 1, "pri_tick");
      step(1, 9, 1, 1, 1, "pri_all");
      check("pri_out", 32'(out0), 32'd9);

      // Zero start and held start after expiry.
      step(1, 0, 0, 0, 0, "z_load");
      step(0, 0, 1, 0, 0, "z_start");
      step(0, 0, 1, 0, 1, "z_hold");
      step(0, 0, 0, 0, 1, "z_idle");

      // Reload instance cycles 3,2,1,3...
      step(1, 3, 0, 0, 0, "rl_load");
      step(0, 0, 1, 0, 0, "rl_start");
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, "rl_tick");
      check("rl_busy1", 32'(busy1), 32'd1);

      // Asynchronous reset mid-run at out=5.
      step(1, 5, 0, 0, 0, "rst_load");
      step(0, 0, 1, 0, 0, "rst_start");
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_all("async_rst");
      #2 rst_n = 1'b1;

      // Randomized control mix.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 5, int'($urandom_range(0, 15)),
              $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
              $urandom_range(0, 99) < 60, "rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
